// File: rtl/dram_cache_ctrl.sv
// Lookup/fill master for the DRAM-cache AXI slave: one request at a time,
// tag compare on lookups, line install on fills, saturating hit/miss counters.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for a request, req_ready high
// S_AR    | lookup address presented on AR
// S_R     | waiting for the {tag word, line} beat
// S_AW    | fill address presented on AW
// S_W     | fill line presented on W
// S_B     | waiting for the write response
// S_RESP  | response held until the requester accepts it
module dram_cache_ctrl #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int TAG_S    = 64,
    parameter int INDEX_W  = 26,
    parameter int OFFSET_W = 6,
    parameter int ID_W     = 16,
    parameter int ID       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_write,
    output logic                    resp_hit,
    output logic                    resp_dirty,
    output logic [DATA_W-1:0]       resp_data,
    output logic [ID_W-1:0]         arid,
    output logic [ADDR_W-1:0]       araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_W-1:0]         rid,
    input  logic [TAG_S+DATA_W-1:0] rdata,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ID_W-1:0]         awid,
    output logic [ADDR_W-1:0]       awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_W-1:0]         wid,
    output logic [DATA_W-1:0]       wdata,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_W-1:0]         bid,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);
    localparam int TAGF_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int VALID_B = TAG_S + DATA_W - 1;
    localparam int DIRTY_B = TAG_S + DATA_W - 2;
    localparam int TAG_HI  = TAG_S + DATA_W - 3;

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                write_q;
    logic [TAGF_W-1:0]   stored_tag;
    logic                lookup_hit;
    logic                unused_inputs;

    assign arid   = ID_W'(ID);
    assign awid   = ID_W'(ID);
    assign wid    = ID_W'(ID);
    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign wdata  = wdata_q;

    // An uninitialised line may carry X in its valid bit; only a clean 1 hits.
    assign stored_tag = rdata[TAG_HI -: TAGF_W];
    assign lookup_hit = (rdata[VALID_B] === 1'b1) &&
                        (stored_tag == addr_q[ADDR_W-1 -: TAGF_W]);

    assign unused_inputs = ^{rid, bid, rdata[TAG_HI-TAGF_W:DATA_W], write_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_hit   <= 1'b0;
            resp_dirty <= 1'b0;
            resp_data  <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        write_q   <= req_write;
                        if (req_write) begin
                            awvalid <= 1'b1;
                            state   <= S_AW;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_write <= 1'b0;
                        resp_hit   <= lookup_hit;
                        resp_dirty <= lookup_hit & rdata[DIRTY_B];
                        resp_data  <= lookup_hit ? rdata[DATA_W-1:0] : '0;
                        if (lookup_hit) begin
                            if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
                        end else begin
                            if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
                        end
                        state <= S_RESP;
                    end
                end
                S_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        state   <= S_W;
                    end
                end
                S_W: begin
                    if (wready) begin
                        wvalid <= 1'b0;
                        bready <= 1'b1;
                        state  <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_write <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_dirty <= 1'b0;
                        resp_data  <= '0;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dram_cache_ctrl.sv
// Bench for dram_cache_ctrl: behavioural AXI slave with its own line store,
// a map-based reference of what the cache should hold, tables plus random requests.
module tb_dram_cache_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_write;
    logic [63:0]  req_addr;
    logic [511:0] req_wdata;
    logic         resp_valid, resp_ready, resp_write, resp_hit, resp_dirty;
    logic [511:0] resp_data;
    logic [15:0]  arid, rid, awid, wid, bid;
    logic [63:0]  araddr, awaddr;
    logic         arvalid, arready, rvalid, rready;
    logic [575:0] rdata;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic [511:0] wdata;
    logic [31:0]  hit_cnt, miss_cnt;

    dram_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_hit(resp_hit), .resp_dirty(resp_dirty), .resp_data(resp_data),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave-side store (what the DUT actually wrote) and reference store (what it should hold).
    logic [63:0]  sl_tag   [logic [25:0]];
    logic [511:0] sl_line  [logic [25:0]];
    logic [63:0]  ref_tag  [logic [25:0]];
    logic [511:0] ref_line [logic [25:0]];
    logic [31:0]  exp_hit = 0;
    logic [31:0]  exp_miss = 0;

    int ar_dly = 1, r_dly = 1, aw_dly = 1, w_dly = 1, b_dly = 1;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, b_pend;
    logic [63:0]  sl_araddr, sl_awaddr;
    logic [511:0] sl_wdata;

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // Absent lines come back invalid but with a matching tag and junk data.
    function automatic logic [575:0] slave_read(input logic [63:0] a);
        logic [25:0] idx;
        idx = a[31:6];
        if (sl_tag.exists(idx)) return {sl_tag[idx], sl_line[idx]};
        return {2'b00, a[63:32], 30'h0, {16{32'hDEAD_BEEF}}};
    endfunction

    // Each channel answers after the request has been visible for (delay+1) negedges.
    initial begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata = '0; rid = '0; bid = '0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                r_pend = 0; b_pend = 0;
            end else begin
                if (arready) begin
                    arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
                end else if (arvalid) begin
                    ar_cnt++;
                    if (ar_cnt > ar_dly) begin arready = 1; sl_araddr = araddr; end
                end
                if (rvalid) begin
                    rvalid = 0; r_pend = 0; rdata = '0;
                end else if (r_pend) begin
                    r_cnt++;
                    if (r_cnt > r_dly) begin
                        rvalid = 1; rdata = slave_read(sl_araddr); rid = 16'($urandom);
                    end
                end
                if (awready) begin
                    awready = 0; aw_cnt = 0;
                end else if (awvalid) begin
                    aw_cnt++;
                    if (aw_cnt > aw_dly) begin awready = 1; sl_awaddr = awaddr; end
                end
                if (wready) begin
                    wready = 0; w_cnt = 0; b_pend = 1; b_cnt = 0;
                end else if (wvalid) begin
                    w_cnt++;
                    if (w_cnt > w_dly) begin wready = 1; sl_wdata = wdata; end
                end
                if (bvalid) begin
                    bvalid = 0; b_pend = 0;
                end else if (b_pend) begin
                    b_cnt++;
                    if (b_cnt > b_dly) begin
                        bvalid = 1; bid = 16'($urandom);
                        sl_tag[sl_awaddr[31:6]]  = {2'b10, sl_awaddr[63:32], 30'h0};
                        sl_line[sl_awaddr[31:6]] = sl_wdata;
                    end
                end
            end
        end
    end

    task automatic ref_req(input logic w, input logic [63:0] a, input logic [511:0] d,
                           output logic eh, output logic ed, output logic [511:0] edata);
        logic [25:0] idx;
        logic [31:0] tg;
        idx = a[31:6];
        tg  = a[63:32];
        eh = 0; ed = 0; edata = '0;
        if (w) begin
            ref_tag[idx]  = {2'b10, tg, 30'h0};
            ref_line[idx] = d;
        end else if (ref_tag.exists(idx) && ref_tag[idx][63] == 1'b1 && ref_tag[idx][61:30] == tg) begin
            eh = 1; ed = ref_tag[idx][62]; edata = ref_line[idx];
            if (exp_hit != 32'hFFFF_FFFF) exp_hit++;
        end else begin
            if (exp_miss != 32'hFFFF_FFFF) exp_miss++;
        end
    endtask

    task automatic run_req(input logic w, input logic [63:0] a, input logic [511:0] d, input int hold,
                           input logic eh, input logic ed, input logic [511:0] edata);
        int lat;
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; req_addr = {$urandom, $urandom}; req_wdata = rand_line();
        lat = 1;
        while (!resp_valid && lat < 200) begin
            chk("req_ready_busy", 64'(req_ready), 64'd0);
            if (w) chk("arvalid_on_fill", 64'(arvalid), 64'd0);
            else   chk("awvalid_on_lookup", 64'(awvalid | wvalid), 64'd0);
            if (arvalid) chk("araddr_stable", araddr, a);
            if (awvalid) chk("awaddr_stable", awaddr, a);
            if (wvalid)  chkd("wdata_stable", wdata, d);
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            n_vec++; n_err++;
            $display("FAIL resp_timeout: got no resp_valid within %0d cycles, required one", lat);
            return;
        end
        chk("latency", 64'(lat), w ? 64'(aw_dly + w_dly + b_dly + 4) : 64'(ar_dly + r_dly + 3));
        if (!w) chk("araddr_seen", sl_araddr, a);
        else    chk("awaddr_seen", sl_awaddr, a);
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", 64'(resp_valid), 64'd1);
            chk("resp_write", 64'(resp_write), 64'(w));
            chk("resp_hit", 64'(resp_hit), 64'(eh));
            chk("resp_dirty", 64'(resp_dirty), 64'(ed));
            chkd("resp_data", resp_data, edata);
            chk("req_ready_resp", 64'(req_ready), 64'd0);
            if (h < hold) @(negedge clk);
        end
        resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 0;
        chk("resp_once", 64'(resp_valid), 64'd0);
        chk("hit_cnt", 64'(hit_cnt), 64'(exp_hit));
        chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
    endtask

    task automatic do_req(input logic w, input logic [63:0] a, input logic [511:0] d, input int hold);
        logic eh, ed;
        logic [511:0] edata;
        ref_req(w, a, d, eh, ed, edata);
        run_req(w, a, d, hold, eh, ed, edata);
    endtask

    typedef struct {
        logic         w;
        logic [63:0]  a;
        logic [511:0] d;
        logic         eh;
        logic         ed;
        logic [511:0] edata;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  addr_a, addr_b, ra;
        logic [511:0] pat_a, pat_b;
        logic dmy_h, dmy_d;
        logic [511:0] dmy_data;
        int wait_n;

        addr_a = 64'h0000_0001_0000_0040;
        addr_b = 64'h0000_0002_0000_0040;
        pat_a  = {64{8'hA5}};
        pat_b  = {64{8'h3C}};
        tbl[0] = '{1'b0, addr_a,         '0,    1'b0, 1'b0, '0};
        tbl[1] = '{1'b1, addr_a,         pat_a, 1'b0, 1'b0, '0};
        tbl[2] = '{1'b0, addr_a,         '0,    1'b1, 1'b0, pat_a};
        tbl[3] = '{1'b0, addr_b,         '0,    1'b0, 1'b0, '0};
        tbl[4] = '{1'b1, addr_b,         pat_b, 1'b0, 1'b0, '0};
        tbl[5] = '{1'b0, addr_a | 64'h5, '0,    1'b0, 1'b0, '0};
        tbl[6] = '{1'b0, addr_b | 64'h3F,'0,    1'b1, 1'b0, pat_b};

        rst_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; resp_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_valids", 64'({arvalid, rready, awvalid, wvalid, bready, resp_valid}), 64'd0);
        chk("rst_resp", 64'({resp_write, resp_hit, resp_dirty}), 64'd0);
        chkd("rst_resp_data", resp_data, '0);
        chk("rst_addr", araddr, 64'd0);
        chkd("rst_wdata", wdata, '0);
        chk("rst_cnts", {hit_cnt, miss_cnt}, 64'd0);
        chk("ids", {arid, awid, wid, 16'd0}, {16'd1, 16'd1, 16'd1, 16'd0});
        rst_n = 1;

        for (int i = 0; i < 7; i++) begin
            ref_req(tbl[i].w, tbl[i].a, tbl[i].d, dmy_h, dmy_d, dmy_data);
            run_req(tbl[i].w, tbl[i].a, tbl[i].d, 0, tbl[i].eh, tbl[i].ed, tbl[i].edata);
        end

        // Slow slave and a stalled requester.
        ar_dly = 3; r_dly = 3; aw_dly = 3; w_dly = 3; b_dly = 3;
        do_req(1'b0, addr_b, '0, 4);
        do_req(1'b1, addr_a, pat_a, 4);
        do_req(1'b0, addr_a, '0, 4);
        ar_dly = 1; r_dly = 1; aw_dly = 1; w_dly = 1; b_dly = 1;

        // Reset while the fill sits in W.
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = addr_b; req_wdata = pat_b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        wait_n = 0;
        while (!wvalid && wait_n < 50) begin @(negedge clk); wait_n++; end
        chk("reached_w", 64'(wvalid), 64'd1);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_w_wvalid", 64'(wvalid), 64'd0);
        chk("rst_w_idle", 64'(req_ready), 64'd1);
        chk("rst_w_cnts", {hit_cnt, miss_cnt}, 64'd0);
        chk("rst_w_resp", 64'(resp_valid), 64'd0);
        rst_n = 1;
        exp_hit = 0; exp_miss = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_w_no_resp", 64'(resp_valid | awvalid | wvalid), 64'd0);
        end
        do_req(1'b0, addr_a, '0, 0);

        // Random traffic over a small tag/index space with preloaded valid/dirty mixes.
        for (int i = 0; i < 8; i++) begin
            logic [63:0] tw;
            logic [511:0] ln;
            tw = {1'($urandom), 1'($urandom), 32'($urandom_range(1, 3)), 30'h0};
            ln = rand_line();
            sl_tag[26'(i + 8)] = tw;  sl_line[26'(i + 8)] = ln;
            ref_tag[26'(i + 8)] = tw; ref_line[26'(i + 8)] = ln;
        end
        for (int i = 0; i < 40; i++) begin
            ra = {32'($urandom_range(1, 3)), 20'h0, 6'($urandom_range(0, 15)), 6'($urandom)};
            ar_dly = $urandom_range(1, 3); r_dly = $urandom_range(1, 3);
            aw_dly = $urandom_range(1, 3); w_dly = $urandom_range(1, 3); b_dly = $urandom_range(1, 3);
            do_req(1'($urandom_range(0, 2) == 0), ra, rand_line(), $urandom_range(0, 2));
        end
        ar_dly = 1; r_dly = 1; aw_dly = 1; w_dly = 1; b_dly = 1;

        // Hit counter pinned at its ceiling.
        do_req(1'b1, addr_a, pat_a, 0);
        @(negedge clk);
        force dut.hit_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.hit_cnt;
        exp_hit = 32'hFFFF_FFFF;
        do_req(1'b0, addr_a, '0, 0);
        chk("hit_sat", 64'(hit_cnt), 64'h0000_0000_FFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dram_cache_ctrl.md
Name: dram_cache_ctrl

Overview:
- Lookup/fill controller that sits directly upstream of the DRAM-cache AXI slave and acts as its AXI master.
- Accepts one request at a time from the requester side:
  - lookup (read): issues AR, receives the {tag, line} beat, compares tags and returns hit/miss plus the line;
  - fill (write): issues AW, W, B to install a line; the slave sets valid=1 and dirty=0 itself.
- Keeps saturating hit and miss counters.

Parameters:
- ADDR_W, 64, request/AXI address width
- DATA_W, 512, cache line width
- TAG_S, 64, stored tag word width; bit TAG_S-1 = valid, TAG_S-2 = dirty, then the tag field, then zero padding
- INDEX_W, 26, set index bits
- OFFSET_W, 6, line offset bits
- ID_W, 16, AXI ID width
- ID, 1, constant ID driven on arid/awid/wid
- TAGF_W = ADDR_W-INDEX_W-OFFSET_W (32), derived tag field width

Ports:
- clk, in, 1, clock
- rst_n, in, 1, synchronous active-low reset
- req_valid, in, 1, request valid
- req_ready, out, 1, high only in IDLE
- req_write, in, 1, 0 = lookup, 1 = fill
- req_addr, in, ADDR_W, byte address
- req_wdata, in, DATA_W, fill line
- resp_valid, out, 1, response valid
- resp_ready, in, 1, response accept
- resp_write, out, 1, echo of req_write
- resp_hit, out, 1, lookup hit (0 for fills)
- resp_dirty, out, 1, stored dirty bit on hit (0 otherwise)
- resp_data, out, DATA_W, line on hit, 0 otherwise
- arid, out, ID_W, = ID
- araddr, out, ADDR_W, captured address
- arvalid, out, 1, AR valid
- arready, in, 1, AR ready
- rid, in, ID_W, ignored
- rdata, in, TAG_S+DATA_W, {tag word, line}
- rvalid, in, 1, R valid
- rready, out, 1, R ready
- awid, out, ID_W, = ID
- awaddr, out, ADDR_W, captured address
- awvalid, out, 1, AW valid
- awready, in, 1, AW ready
- wid, out, ID_W, = ID
- wdata, out, DATA_W, captured line
- wvalid, out, 1, W valid
- wready, in, 1, W ready
- bid, in, ID_W, ignored
- bvalid, in, 1, B valid
- bready, out, 1, B ready
- hit_cnt, out, 32, saturating lookup-hit count
- miss_cnt, out, 32, saturating lookup-miss count

Behaviour:
- Reset: state=IDLE; all valid/ready outputs 0 except req_ready=1; resp_* = 0; captured addr/data = 0; counters = 0. Reset asserted mid-transaction aborts it immediately; no response is issued.
- State machine:
  - IDLE: req_ready=1. On req_valid, capture addr, wdata and write flag. Go to AR (lookup) or AW (fill).
  - AR: arvalid=1, held with araddr stable until the cycle arready=1, then go to R.
  - R: rready=1. On rvalid, register the compare result and go to RESP.
  - AW: awvalid=1 until awready, then go to W. W is not issued before AW completes.
  - W: wvalid=1, wdata stable until wready, then go to B.
  - B: bready=1. On bvalid go to RESP with resp_write=1, hit=0.
  - RESP: resp_valid=1, outputs held stable until resp_ready, then go to IDLE. New req_valid is accepted one cycle later, not in the same cycle.
- Compare:
  - stored_tag = rdata[TAG_S+DATA_W-3 -: TAGF_W];
  - hit = (rdata[TAG_S+DATA_W-1] === 1) && stored_tag == req_addr[ADDR_W-1 : INDEX_W+OFFSET_W].
  - A valid bit of 0 or X (uninitialised line) is a miss.
  - Offset bits take no part in the compare and are passed unchanged on araddr/awaddr.
- Counters: incremented in the R→RESP cycle, hit_cnt on a hit, miss_cnt on a miss. Both saturate at 32'hFFFF_FFFF. Fills count in neither.
- Latency against a slave with 1-cycle ready:
  - lookup: 5 cycles from the req handshake to resp_valid;
  - fill: 7 cycles.
- One outstanding transaction. AXI inputs are ignored outside their owning state; no deadlock if valid arrives early.

Test Plan:
- Lookup addr 0x0000_0001_0000_0040 on an empty cache → resp_hit=0, resp_data=0, miss_cnt=1, araddr=that addr.
- Fill addr 0x0000_0001_0000_0040 with data 512'hA5..A5, then lookup the same addr → B handshake seen, then resp_hit=1, resp_dirty=0, resp_data=A5..A5, hit_cnt=1.
- Lookup 0x0000_0002_0000_0040 (same index, different tag) after the above fill → resp_hit=0, miss_cnt increments.
- Slave arready/awready/wready delayed 3 cycles and resp_ready held low for 4 cycles → arvalid, araddr and the resp_* outputs stay stable throughout, exactly one response, req_ready=0 until resp accepted.
- rst_n pulled low while in W → next cycle state=IDLE, wvalid=0, counters=0, no resp_valid.
- Preload hit_cnt to 32'hFFFF_FFFF (force) and perform a hit → hit_cnt stays 32'hFFFF_FFFF.
